inject_scheduler: RTL and testbench

//  Shares one node's router local injection port (router in5/vi5, credit return co5) among
//  NUM_REQ on-node traffic sources (PE request queues, DMA, etc.) with round-robin fairness.

---
 rtl/noc_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/inject_scheduler.sv | 109 ++++++++++
 tb/tb_inject_scheduler.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC constants and the injection-scheduler state encoding.
package noc_pkg;
  localparam int FLIT_W_DEF    = 20;
  localparam int TAIL_BIT_DEF  = 19;
  localparam int BUF_DEPTH_DEF = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);
  int c;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = int'(ptr) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end
endmodule

// File: rtl/inject_scheduler.sv
// Shares the router local injection port among NUM_REQ sources: round-robin,
// credit-gated, and locked to one source from head flit to tail flit.
module inject_scheduler
  import noc_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int FLIT_W    = FLIT_W_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int TAIL_BIT  = TAIL_BIT_DEF,
  parameter int IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      ci,
  output logic [FLIT_W-1:0]         inject,
  output logic                      inject_valid,
  output logic [CW-1:0]             credits,
  output logic [IW-1:0]             grant_id,
  output logic                      credit_err,
  output logic [15:0]               sent_count
);
  sched_state_t state, next_state;
  logic [IW-1:0] rr_ptr, next_ptr;
  logic [NUM_REQ-1:0][FLIT_W-1:0] flits;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0] arb_idx, sel_idx;
  logic arb_any, transfer, has_credit;
  logic [FLIT_W-1:0] sel_flit;

  assign flits      = req_flit;
  assign has_credit = (credits != '0);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Ready depends only on registered state/credits and the arbiter, never on ci.
  always_comb begin
    req_ready  = '0;
    next_state = state;
    next_ptr   = rr_ptr;
    sel_idx    = (state == IDLE) ? arb_idx : grant_id;
    sel_flit   = flits[sel_idx];
    if (rst && has_credit) begin
      if (state == IDLE) begin
        if (arb_any) req_ready = arb_grant;
      end else begin
        req_ready[grant_id] = 1'b1;
      end
    end
    transfer = |(req_ready & req_valid);
    if (transfer) begin
      next_state = sel_flit[TAIL_BIT] ? IDLE : LOCKED;
      if (state == IDLE)
        next_ptr = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      state  <= next_state;
      rr_ptr <= next_ptr;
      if (transfer && state == IDLE) grant_id <= arb_idx;
    end
  end

  // Simultaneous launch and return cancel; a return at full count is an error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits    <= CW'(BUF_DEPTH);
      credit_err <= 1'b0;
    end else begin
      case ({transfer, ci})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          if (credits == CW'(BUF_DEPTH)) credit_err <= 1'b1;
          else                           credits    <= credits + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inject       <= '0;
      inject_valid <= 1'b0;
      sent_count   <= '0;
    end else begin
      inject_valid <= transfer;
      if (transfer) begin
        inject     <= sel_flit;
        sent_count <= sent_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_inject_scheduler.sv
// Directed bench for inject_scheduler: arbitration, credits, packet lock, reset, wrap.
module tb_inject_scheduler;
  localparam int NR = 4;
  localparam int FW = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*FW-1:0]  req_flit;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic              ci;
  logic [FW-1:0]     inject;
  logic              inject_valid;
  logic [2:0]        credits;
  logic [1:0]        grant_id;
  logic              credit_err;
  logic [15:0]       sent_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inject_scheduler #(.NUM_REQ(NR), .FLIT_W(FW), .BUF_DEPTH(4), .TAIL_BIT(19)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_flit     (req_flit),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .ci           (ci),
    .inject       (inject),
    .inject_valid (inject_valid),
    .credits      (credits),
    .grant_id     (grant_id),
    .credit_err   (credit_err),
    .sent_count   (sent_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_flit(input int i, input logic [FW-1:0] f);
    req_flit[i*FW +: FW] = f;
  endtask

  initial begin
    logic [3:0] exp_rdy;
    rst = 1'b0; req_flit = '0; req_valid = '0; ci = 1'b0;
    tick; tick;
    chk("rst_credits", 32'(credits), 32'd4);
    chk("rst_ivalid", 32'(inject_valid), 32'd0);
    chk("rst_inject", 32'(inject), 32'd0);
    chk("rst_sent", 32'(sent_count), 32'd0);
    chk("rst_err", 32'(credit_err), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    rst = 1'b1;

    // Fairness: all four single-flit sources, credit returned every cycle.
    for (int i = 0; i < NR; i++) set_flit(i, 20'h80000 | 20'(i));
    req_valid = 4'hF; ci = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_rdy = 4'b0001 << (k % 4);
      chk("rr_ready", 32'(req_ready), 32'(exp_rdy));
      tick;
      chk("rr_ivalid", 32'(inject_valid), 32'd1);
      chk("rr_inject", 32'(inject), 32'(20'h80000 | 20'(k % 4)));
      chk("rr_grant", 32'(grant_id), 32'(k % 4));
      chk("rr_credits", 32'(credits), 32'd4);
    end
    chk("rr_sent8", 32'(sent_count), 32'd8);
    req_valid = '0; ci = 1'b0;
    tick;
    chk("rr_idle_ivalid", 32'(inject_valid), 32'd0);
    chk("rr_hold_inject", 32'(inject), 32'h80003);
    chk("rr_no_err", 32'(credit_err), 32'd0);

    // Credit stall: only req0, no credit return.
    req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cs_ready", 32'(req_ready), 32'b0001);
      tick;
      chk("cs_credits", 32'(credits), 32'(3 - k));
    end
    #1;
    chk("cs_ready0", 32'(req_ready), 32'd0);
    chk("cs_sent12", 32'(sent_count), 32'd12);
    tick;
    chk("cs_stall_ivalid", 32'(inject_valid), 32'd0);
    ci = 1'b1;
    #1;
    chk("cs_no_ci_path", 32'(req_ready), 32'd0);
    tick;
    ci = 1'b0;
    chk("cs_credit1", 32'(credits), 32'd1);
    #1;
    chk("cs_ready_again", 32'(req_ready), 32'b0001);
    tick;
    chk("cs_one_more", 32'(inject_valid), 32'd1);
    chk("cs_credits0", 32'(credits), 32'd0);
    chk("cs_sent13", 32'(sent_count), 32'd13);
    tick;
    chk("cs_stall2", 32'(inject_valid), 32'd0);
    req_valid = '0; ci = 1'b1;
    repeat (4) tick;
    ci = 1'b0;
    chk("cs_refill", 32'(credits), 32'd4);

    // Packet lock: req1 three-flit packet while req2 waits (rr_ptr is now 1).
    set_flit(1, 20'h01001); set_flit(2, 20'h82000);
    req_valid = 4'b0110;
    #1; chk("pl_head_ready", 32'(req_ready), 32'b0010);
    tick;
    chk("pl_f1", 32'(inject), 32'h01001);
    chk("pl_grant1", 32'(grant_id), 32'd1);
    set_flit(1, 20'h01002);
    #1; chk("pl_body_ready", 32'(req_ready), 32'b0010);
    tick;
    chk("pl_f2", 32'(inject), 32'h01002);
    req_valid = 4'b0100;
    #1; chk("pl_bubble_ready", 32'(req_ready), 32'b0010);
    tick;
    chk("pl_bubble_ivalid", 32'(inject_valid), 32'd0);
    set_flit(1, 20'h81003); req_valid = 4'b0110;
    #1; chk("pl_tail_ready", 32'(req_ready), 32'b0010);
    tick;
    chk("pl_f3", 32'(inject), 32'h81003);
    chk("pl_f3_valid", 32'(inject_valid), 32'd1);
    req_valid = 4'b0100;
    #1; chk("pl_req2_ready", 32'(req_ready), 32'b0100);
    tick;
    chk("pl_req2_flit", 32'(inject), 32'h82000);
    chk("pl_grant2", 32'(grant_id), 32'd2);
    chk("pl_credits0", 32'(credits), 32'd0);
    req_valid = '0; ci = 1'b1;
    repeat (4) tick;
    ci = 1'b0;

    // Simultaneous launch/return, then overflow return.
    req_valid = 4'b0001;
    tick; tick;
    chk("sim_credits2", 32'(credits), 32'd2);
    ci = 1'b1;
    tick;
    chk("sim_same_cycle", 32'(credits), 32'd2);
    chk("sim_ivalid", 32'(inject_valid), 32'd1);
    req_valid = '0;
    tick; tick;
    chk("sim_full", 32'(credits), 32'd4);
    chk("sim_err0", 32'(credit_err), 32'd0);
    tick;
    ci = 1'b0;
    chk("sim_over_credits", 32'(credits), 32'd4);
    chk("sim_err1", 32'(credit_err), 32'd1);
    tick;
    chk("sim_err_sticky", 32'(credit_err), 32'd1);
    chk("sim_sent20", 32'(sent_count), 32'd20);

    // Reset mid-packet: open a packet on req1, then drop reset between edges.
    set_flit(1, 20'h01111); req_valid = 4'b0010;
    tick;
    req_valid = 4'b0100;
    #1; chk("mr_locked", 32'(req_ready), 32'b0010);
    #1; rst = 1'b0;
    #1;
    chk("mr_credits", 32'(credits), 32'd4);
    chk("mr_ivalid", 32'(inject_valid), 32'd0);
    chk("mr_sent", 32'(sent_count), 32'd0);
    chk("mr_err", 32'(credit_err), 32'd0);
    chk("mr_grant", 32'(grant_id), 32'd0);
    chk("mr_ready_in_rst", 32'(req_ready), 32'd0);
    #2; rst = 1'b1;
    #1; chk("mr_lock_dropped", 32'(req_ready), 32'b0100);
    req_valid = '0;
    tick;

    // Counter wrap: req0 streams single flits with a credit back every cycle.
    req_valid = 4'b0001; ci = 1'b1;
    repeat (65534) tick;
    chk("wr_fffe", 32'(sent_count), 32'hFFFE);
    tick; tick;
    chk("wr_zero", 32'(sent_count), 32'h0000);
    chk("wr_credits", 32'(credits), 32'd4);
    chk("wr_no_err", 32'(credit_err), 32'd0);
    req_valid = '0; ci = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
